// File: rtl/jk_pkg.sv
// Shared command and FSM encodings for the JK command front end.
// {j,k} bit order lets a command be built directly from the two rise pulses.
package jk_pkg;

  typedef logic [1:0] jk_cmd_t;

  localparam jk_cmd_t CMD_HOLD   = 2'b00;
  localparam jk_cmd_t CMD_CLR    = 2'b01;
  localparam jk_cmd_t CMD_SET    = 2'b10;
  localparam jk_cmd_t CMD_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EMIT = 2'd2
  } jk_state_e;

  function automatic jk_cmd_t cmd_from_rises(input logic set_rise, input logic clr_rise);
    return {set_rise, clr_rise};
  endfunction

endpackage

// File: rtl/jk_debounce_ch.sv
// One button channel: 2-flop synchroniser, level debouncer and rise pulse.
// Auto-repeat of the rise pulse is compiled in with AUTO_REPEAT_EN.
module jk_debounce_ch
  import jk_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned REPEAT_CYCLES   = 64
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic stable,
  output logic rise
);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             edge_rise;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
    end
  end

  assign accept    = (sync2_q != stable_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign edge_rise = accept && sync2_q;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (accept) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

`ifdef AUTO_REPEAT_EN
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             rep_fire;

  // Period counts from the last rise, real or synthetic.
  assign rep_fire = stable_q && (rep_q == CNT_W'(REPEAT_CYCLES - 1));

  always_comb begin
    rep_d = rep_q;
    if (!stable_q || rep_fire) begin
      rep_d = '0;
    end else begin
      rep_d = rep_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end

  assign rise_d = edge_rise || rep_fire;
`else
  // The repeat period is only meaningful with auto-repeat compiled in.
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_CYCLES;
  assign rise_d        = edge_rise;
`endif

  assign stable = stable_q;
  assign rise   = rise_q;

endmodule

// File: rtl/jk_cmd_debounce.sv
// Debounced set/clear buttons to one-cycle JK commands, with press pairing into TOGGLE.
// Optional auto-repeat while a button is held: define AUTO_REPEAT_EN.
module jk_cmd_debounce
  import jk_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned PAIR_WIN        = 4,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned REPEAT_CYCLES   = 64
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_set,
  input  logic btn_clr,
  output logic j,
  output logic k,
  output logic cmd_valid,
  output logic busy
);

  logic set_rise, clr_rise;
  logic set_stable, clr_stable;

  jk_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_set_ch (
    .clk   (clk),
    .rstn  (rstn),
    .raw   (btn_set),
    .stable(set_stable),
    .rise  (set_rise)
  );

  jk_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_clr_ch (
    .clk   (clk),
    .rstn  (rstn),
    .raw   (btn_clr),
    .stable(clr_stable),
    .rise  (clr_rise)
  );

  // Debounced levels are not needed by the pairing logic.
  logic unused_stable;
  assign unused_stable = set_stable ^ clr_stable;

  jk_state_e        state_q, state_d;
  jk_cmd_t          pend_q, pend_d;
  jk_cmd_t          out_q, out_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             valid_q, valid_d;
  logic             partner;

  assign partner = ((pend_q == CMD_SET) && clr_rise) || ((pend_q == CMD_CLR) && set_rise);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    timer_d = timer_q;
    unique case (state_q)
      ST_IDLE: begin
        if (set_rise || clr_rise) begin
          pend_d = cmd_from_rises(set_rise, clr_rise);
          if ((set_rise && clr_rise) || (PAIR_WIN == 0)) begin
            state_d = ST_EMIT;
          end else begin
            state_d = ST_WAIT;
            timer_d = CNT_W'(PAIR_WIN);
          end
        end
      end
      ST_WAIT: begin
        // Same-channel rises while waiting are ignored; only the partner matters.
        if (partner) begin
          pend_d  = CMD_TOGGLE;
          state_d = ST_EMIT;
        end else if (timer_q <= CNT_W'(1)) begin
          state_d = ST_EMIT;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      ST_EMIT: begin
        state_d = ST_IDLE;
        pend_d  = CMD_HOLD;
      end
      default: begin
        state_d = ST_IDLE;
        pend_d  = CMD_HOLD;
      end
    endcase

    valid_d = (state_d == ST_EMIT);
    out_d   = valid_d ? pend_d : CMD_HOLD;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      pend_q  <= CMD_HOLD;
      timer_q <= '0;
      out_q   <= CMD_HOLD;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      timer_q <= timer_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign j         = out_q[1];
  assign k         = out_q[0];
  assign cmd_valid = valid_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jk_cmd_debounce.sv
// Bench for jk_cmd_debounce: directed vector table, corner sequences and a random
// run against a rule-level reference model (DEBOUNCE_CYCLES=4, PAIR_WIN=3).
module tb_jk_cmd_debounce;

  localparam int unsigned DEB   = 4;
  localparam int unsigned PW    = 3;
  localparam int unsigned CW    = 8;
  localparam int unsigned REP   = 8;
  localparam int          NRAND = 1500;

  localparam logic [1:0] C_HOLD = 2'b00;
  localparam logic [1:0] C_CLR  = 2'b01;
  localparam logic [1:0] C_SET  = 2'b10;
  localparam logic [1:0] C_TOG  = 2'b11;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic btn_set = 1'b0;
  logic btn_clr = 1'b0;
  logic j, k, cmd_valid, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jk_cmd_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .PAIR_WIN       (PW),
    .CNT_W          (CW),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .btn_set  (btn_set),
    .btn_clr  (btn_clr),
    .j        (j),
    .k        (k),
    .cmd_valid(cmd_valid),
    .busy     (busy)
  );

  // Downstream JK flip-flop fed by the command outputs.
  logic jk_q;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) jk_q <= 1'b0;
    else begin
      case ({j, k})
        2'b10:   jk_q <= 1'b1;
        2'b01:   jk_q <= 1'b0;
        2'b11:   jk_q <= ~jk_q;
        default: jk_q <= jk_q;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-run log of command cycles, relative to the first driven cycle.
  int         vt[$];
  logic [1:0] vc[$];
  int         bad_jk;

  task automatic run_seq(input int s_at, input int s_len, input int c_at, input int c_len,
                         input int total);
    vt.delete();
    vc.delete();
    bad_jk = 0;
    for (int c = 0; c < total; c++) begin
      btn_set = (s_len > 0) && (c >= s_at) && (c < s_at + s_len);
      btn_clr = (c_len > 0) && (c >= c_at) && (c < c_at + c_len);
      step();
      if (cmd_valid) begin
        vt.push_back(c + 1);
        vc.push_back({j, k});
      end else if (j || k) begin
        bad_jk++;
      end
    end
    btn_set = 1'b0;
    btn_clr = 1'b0;
  endtask

  typedef struct {
    int         s_at;
    int         s_len;
    int         c_at;
    int         c_len;
    int         n;
    logic [1:0] cmd0;
    int         at0;
    logic [1:0] cmd1;
    int         at1;
  } vec_t;

  vec_t vecs[10];

  // Random run: stimulus and model outputs.
  logic       raw_m  [2][NRAND];
  logic       stab_m [2][NRAND+1];
  logic       rise_m [2][NRAND+1];
  logic [1:0] e_cmd  [NRAND+2];
  logic       e_val  [NRAND+2];
  logic       e_busy [NRAND+2];

  task automatic build_model();
    for (int ch = 0; ch < 2; ch++) begin
      logic st;
      int   last;
      st = 1'b0;
      stab_m[ch][0] = 1'b0;
      rise_m[ch][0] = 1'b0;
      for (int e = 1; e <= NRAND; e++) begin
        // Sync level seen at edge x is the raw level driven in cycle x-3.
        logic all_diff;
        all_diff = 1'b1;
        for (int w = 0; w < int'(DEB); w++) begin
          logic sv;
          sv = (e - w - 3 >= 0) ? raw_m[ch][e-w-3] : 1'b0;
          if (sv == st) all_diff = 1'b0;
        end
        rise_m[ch][e] = all_diff && !st;
        if (all_diff) st = !st;
        stab_m[ch][e] = st;
      end
`ifdef AUTO_REPEAT_EN
      last = -1;
      for (int c = 1; c <= NRAND; c++) begin
        if (rise_m[ch][c]) last = c;
        else if (last >= 0 && c - last == int'(REP)) begin
          rise_m[ch][c] = 1'b1;
          last = c;
        end
        if (!stab_m[ch][c]) last = -1;
      end
`else
      last = 0;
`endif
    end

    for (int c = 0; c < NRAND + 2; c++) begin
      e_cmd[c]  = C_HOLD;
      e_val[c]  = 1'b0;
      e_busy[c] = 1'b0;
    end
    begin
      int free;
      free = 1;
      for (int t = 1; t <= NRAND; t++) begin
        logic s, cl, found;
        int e_at;
        logic [1:0] cmd;
        s  = rise_m[0][t];
        cl = rise_m[1][t];
        if (t >= free && (s || cl)) begin
          if (s && cl) begin
            cmd  = C_TOG;
            e_at = t + 1;
          end else begin
            cmd   = s ? C_SET : C_CLR;
            e_at  = t + int'(PW) + 1;
            found = 1'b0;
            for (int m = t + 1; m <= t + int'(PW); m++) begin
              if (!found && m <= NRAND && (s ? rise_m[1][m] : rise_m[0][m])) begin
                found = 1'b1;
                cmd   = C_TOG;
                e_at  = m + 1;
              end
            end
          end
          for (int b = t + 1; b <= e_at && b < NRAND + 2; b++) e_busy[b] = 1'b1;
          if (e_at < NRAND + 2) begin
            e_cmd[e_at] = cmd;
            e_val[e_at] = 1'b1;
          end
          free = e_at + 1;
        end
      end
    end
  endtask

  initial begin
    vecs[0] = '{0, 3, 0, 0, 0, C_HOLD, 0,  C_HOLD, 0};   // glitch
    vecs[1] = '{0, 4, 0, 0, 1, C_SET,  10, C_HOLD, 0};   // shortest accepted press
    vecs[2] = '{0, 5, 0, 0, 1, C_SET,  10, C_HOLD, 0};
    vecs[3] = '{0, 0, 0, 5, 1, C_CLR,  10, C_HOLD, 0};
    vecs[4] = '{0, 5, 0, 5, 1, C_TOG,  7,  C_HOLD, 0};   // same-cycle pair
    vecs[5] = '{0, 5, 2, 5, 1, C_TOG,  9,  C_HOLD, 0};
    vecs[6] = '{0, 5, 3, 5, 1, C_TOG,  10, C_HOLD, 0};   // partner on last window cycle
    vecs[7] = '{0, 5, 4, 5, 1, C_SET,  10, C_HOLD, 0};   // partner lands in EMIT, dropped
    vecs[8] = '{0, 5, 5, 5, 2, C_SET,  10, C_CLR,  15};
    vecs[9] = '{1, 5, 0, 5, 1, C_TOG,  8,  C_HOLD, 0};

    // Reset held with buttons toggling.
    rstn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      btn_set = i[0];
      btn_clr = i[1];
      step();
      check("reset_outs", {j, k, cmd_valid, busy}, 4'b0);
    end
    btn_set = 1'b0;
    btn_clr = 1'b0;
    rstn    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("post_reset_idle", {j, k, cmd_valid, busy}, 4'b0);
    end

    // Directed vector table.
    for (int v = 0; v < 10; v++) begin
      run_seq(vecs[v].s_at, vecs[v].s_len, vecs[v].c_at, vecs[v].c_len, 30);
      repeat (20) step();
      check($sformatf("vec%0d_count", v), vt.size(), vecs[v].n);
      check($sformatf("vec%0d_jk_outside_valid", v), bad_jk, 0);
      check($sformatf("vec%0d_idle_busy", v), busy, 1'b0);
      if (vecs[v].n >= 1 && vt.size() >= 1) begin
        check($sformatf("vec%0d_cycle0", v), vt[0], vecs[v].at0);
        check($sformatf("vec%0d_cmd0", v), vc[0], vecs[v].cmd0);
      end
      if (vecs[v].n >= 2 && vt.size() >= 2) begin
        check($sformatf("vec%0d_cycle1", v), vt[1], vecs[v].at1);
        check($sformatf("vec%0d_cmd1", v), vc[1], vecs[v].cmd1);
      end
    end

    // JK flip-flop follows SET then TOGGLE.
    run_seq(0, 5, 0, 0, 20);
    check("jk_after_set", jk_q, 1'b1);
    run_seq(0, 5, 0, 5, 20);
    check("jk_after_toggle", jk_q, 1'b0);
    repeat (20) step();

    // Reset one cycle into WAIT: rise at cycle 6, WAIT from cycle 7.
    btn_set = 1'b1;
    repeat (8) step();
    check("midwait_busy_before", busy, 1'b1);
    rstn    = 1'b0;
    btn_set = 1'b0;
    #1;
    check("midwait_reset_outs", {j, k, cmd_valid, busy}, 4'b0);
    step();
    rstn = 1'b1;
    run_seq(0, 0, 0, 0, 20);
    check("midwait_no_cmd", vt.size(), 0);
    check("midwait_busy_after", busy, 1'b0);

`ifdef AUTO_REPEAT_EN
    run_seq(0, 40, 0, 0, 70);
    check("repeat_min_count", vt.size() >= 4, 1'b1);
    for (int i = 1; i < vt.size(); i++) begin
      check($sformatf("repeat_period%0d", i), vt[i] - vt[i-1], REP);
      check($sformatf("repeat_cmd%0d", i), vc[i], C_SET);
    end
`else
    run_seq(0, 60, 0, 0, 90);
    check("hold_one_cmd", vt.size(), 1);
    if (vt.size() >= 1) check("hold_cmd", vc[0], C_SET);
`endif
    repeat (20) step();

    // Random bouncy stimulus against the reference model.
    for (int ch = 0; ch < 2; ch++) begin
      logic lvl;
      int   c;
      lvl = 1'b0;
      c   = 0;
      while (c < NRAND) begin
        int len;
        len = int'($urandom_range(1, 14));
        for (int i = 0; i < len && c < NRAND; i++) begin
          raw_m[ch][c] = lvl;
          c++;
        end
        lvl = !lvl;
      end
    end
    build_model();
    rstn    = 1'b0;
    btn_set = 1'b0;
    btn_clr = 1'b0;
    repeat (2) step();
    rstn = 1'b1;
    for (int c = 0; c < NRAND; c++) begin
      btn_set = raw_m[0][c];
      btn_clr = raw_m[1][c];
      step();
      check($sformatf("rand_c%0d", c + 1), {j, k, cmd_valid, busy},
            {e_cmd[c+1], e_val[c+1], e_busy[c+1]});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_cmd_debounce.md
Name: jk_cmd_debounce

Overview:
- Upstream command stage for the JK master-slave flip-flop; produces its j/k inputs.
- Takes two raw, bouncy pushbuttons (set, clear), synchronises and debounces each, and converts their press edges into one-cycle JK commands.
- Near-simultaneous presses merge into a TOGGLE command (j=k=1).
- With no command pending, the JK flip-flop sees HOLD (j=k=0).

Parameters:
- DEBOUNCE_CYCLES, 16: cycles a synchronised input must hold a new level before it is accepted; legal range is 1 or more.
- PAIR_WIN, 4: cycles to wait after one press for the partner press before emitting a single command; 0 disables pairing except same-cycle presses.
- CNT_W, 8: width of the debounce, pair and repeat counters; must hold DEBOUNCE_CYCLES, PAIR_WIN and REPEAT_CYCLES.
- REPEAT_CYCLES, 64: auto-repeat period; used only when AUTO_REPEAT_EN is defined.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- btn_set  in  1  raw set button, asynchronous to clk
- btn_clr  in  1  raw clear button, asynchronous to clk
- j  out  1  JK j input, registered
- k  out  1  JK k input, registered
- cmd_valid  out  1  high for exactly the cycle j/k carry a command
- busy  out  1  high while FSM not IDLE

Behaviour:
- Reset (rstn=0, async):
  - all synchroniser flops, stable levels, counters = 0; FSM = IDLE.
  - j=0, k=0, cmd_valid=0, busy=0.
  - Release is synchronous to the next clk edge.
- Per channel, the synchroniser is 2 flops.
- Debounce:
  - The counter increments while sync != stable.
  - The counter clears when sync == stable.
  - When the count reaches DEBOUNCE_CYCLES-1 with sync still differing, stable takes the sync value and the counter clears.
- A rise is a one-cycle pulse on the stable 0->1 transition. Release edges generate nothing.
- Latency, raw edge to rise pulse: 2 + DEBOUNCE_CYCLES cycles.
- Command encoding {j,k}: HOLD=00, CLR=01, SET=10, TOGGLE=11.
- FSM states are IDLE, WAIT and EMIT. j, k and cmd_valid are registered; they are nonzero only in EMIT.
- IDLE:
  - Both rises in the same cycle: pending=TOGGLE, go to EMIT.
  - One rise with PAIR_WIN=0: pending=that command, go to EMIT.
  - One rise with PAIR_WIN>0: pending=that command, timer=PAIR_WIN, go to WAIT.
- WAIT:
  - Partner rise: pending=TOGGLE, go to EMIT.
  - Else a repeated rise on the same channel is ignored.
  - The timer decrements each cycle; timer==1 with no partner goes to EMIT.
- EMIT:
  - {j,k}=pending and cmd_valid=1 for exactly one cycle, then IDLE.
  - Any rise arriving during EMIT is dropped.
- Timing, rise pulse at cycle N:
  - Single press: j/k high at N+PAIR_WIN+1.
  - Same-cycle pair: high at N+1.
  - Partner rise at M in WAIT: high at M+1.
- busy = (state != IDLE).
- Reset mid-operation: pending is discarded, no command is emitted, and outputs are 0 immediately.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - Per channel, a repeat counter runs while stable=1.
  - Every REPEAT_CYCLES cycles after the last rise (real or synthetic), a synthetic rise is generated.
  - Synthetic rises follow the same FSM pairing rules.
  - The counter clears when stable=0 or in reset.
- Undefined: no repeat logic; holding a button yields exactly one command per press.

Decomposition:
- Package jk_pkg:
  - 2-bit command constants CMD_HOLD, CMD_CLR, CMD_SET, CMD_TOGGLE.
  - FSM state encodings ST_IDLE, ST_WAIT, ST_EMIT.
- Sub-module jk_debounce_ch:
  - Ports clk, rstn, raw, stable, rise; parameters DEBOUNCE_CYCLES, CNT_W; holds the optional repeat logic.
  - Instantiated twice.
- Top: pairing FSM and output registers.

Test Plan:
- DEBOUNCE_CYCLES=4, PAIR_WIN=3 in all scenarios.
1. Reset: rstn=0 with buttons toggling -> j=k=cmd_valid=busy=0 throughout; after release, 10 idle cycles produce no command.
2. Glitch: btn_set high for 3 cycles then low -> no rise, j never asserts, busy stays 0.
3. Single set: btn_set held high -> rise at edge+6; j=1,k=0,cmd_valid=1 for one cycle 4 cycles after the rise; feeding the JK flip-flop sets q=1.
4. Paired toggle: btn_set rise, then btn_clr rise 2 cycles later -> j=k=1 for one cycle, 1 cycle after the clr rise; no separate SET is emitted.
5. Timeout clear: btn_clr only -> j=0,k=1 after PAIR_WIN+1; a second clr rise inside WAIT does not extend the window or emit a second command.
6. Reset mid-WAIT: rstn pulsed low 1 cycle into WAIT -> no command emitted, busy=0, state IDLE. With AUTO_REPEAT_EN and REPEAT_CYCLES=8, btn_set held 40 cycles -> SET emitted repeatedly, one command per 8 cycles after the first.
